// File: rtl/clk_mux_cfg_pkg.sv
// rtl/clk_mux_cfg_pkg.sv - shared types and field layout for the clock mux config loader
package clk_mux_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_CHECK,
        ST_POST
    } state_t;

    localparam int         WORD_W   = 7;
    localparam int         CBIT_W   = 6;
    localparam logic [3:0] SEL_MAX  = 4'd11;
    localparam int         CENB_BIT = 6;
    localparam int         POL_BIT  = 5;
    localparam int         EN_BIT   = 4;

    // An enabled mux must select one of the 12 real clock inputs.
    function automatic logic sel_bad(input logic [WORD_W-1:0] word);
        return word[EN_BIT] && (word[EN_BIT-1:0] > SEL_MAX);
    endfunction

endpackage

// File: rtl/clk_mux_cfg_slot.sv
// rtl/clk_mux_cfg_slot.sv - shadow and active configuration registers for one clock mux
module clk_mux_cfg_slot
    import clk_mux_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_en,
    input  logic              commit,
    input  logic              clear,
    input  logic [WORD_W-1:0] wr_data,
    output logic [CBIT_W-1:0] cbit,
    output logic [CBIT_W-1:0] cbitb,
    output logic              cenb,
    output logic              bad_sel
);

    logic [WORD_W-1:0] shadow;

    // Shadow word collects the incoming frame; an abort throws it away.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            shadow <= '0;
        end else if (clear) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow <= wr_data;
        end
    end

    // Active bits and their complement move together, only on commit.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cbit  <= '0;
            cbitb <= '1;
            cenb  <= 1'b1;
        end else if (commit) begin
            cbit  <= {shadow[POL_BIT], shadow[EN_BIT], shadow[EN_BIT-1:0]};
            cbitb <= ~{shadow[POL_BIT], shadow[EN_BIT], shadow[EN_BIT-1:0]};
            cenb  <= shadow[CENB_BIT];
        end
    end

    assign bad_sel = sel_bad(shadow);

endmodule

// File: rtl/clk_mux_cfg_loader.sv
// rtl/clk_mux_cfg_loader.sv - framed, validated, prog-gated loader for a bank of 12:1 clock muxes
module clk_mux_cfg_loader
    import clk_mux_cfg_pkg::*;
#(
    parameter int NUM_MUX    = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [WORD_W-1:0]         cfg_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      prog,
    output logic [NUM_MUX*CBIT_W-1:0] cbit,
    output logic [NUM_MUX*CBIT_W-1:0] cbitb,
    output logic [NUM_MUX-1:0]        cenb
);

    localparam int               IDX_W    = (NUM_MUX > 1) ? $clog2(NUM_MUX) : 1;
    localparam int               CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MUX - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               frame_ok;
    logic [NUM_MUX-1:0] bad_vec;
    logic               any_bad;
    logic               load_wr;
    logic               commit;
    logic               clear;

    assign any_bad = |bad_vec;
    assign load_wr = (state == ST_LOAD) && cfg_valid && cfg_ready && !cfg_abort;
    assign commit  = (state == ST_CHECK) && !any_bad;
    assign clear   = ((state == ST_PRE) || (state == ST_LOAD)) && cfg_abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MUX; gi++) begin : g_slot
            clk_mux_cfg_slot u_slot (
                .clk     (clk),
                .rstb    (rstb),
                .wr_en   (load_wr && (idx == IDX_W'(gi))),
                .commit  (commit),
                .clear   (clear),
                .wr_data (cfg_data),
                .cbit    (cbit[gi*CBIT_W +: CBIT_W]),
                .cbitb   (cbitb[gi*CBIT_W +: CBIT_W]),
                .cenb    (cenb[gi]),
                .bad_sel (bad_vec[gi])
            );
        end
    endgenerate

    // Frame sequencer: prog brackets the whole frame so active bits only move under it.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            frame_ok  <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            prog      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state <= ST_PRE;
                        cnt   <= CNT_INIT;
                        prog  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cfg_abort) begin
                        state    <= ST_POST;
                        cnt      <= CNT_INIT;
                        frame_ok <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= ST_LOAD;
                        idx       <= '0;
                        cfg_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (cfg_abort) begin
                        state     <= ST_POST;
                        cnt       <= CNT_INIT;
                        idx       <= '0;
                        cfg_ready <= 1'b0;
                        frame_ok  <= 1'b0;
                    end else if (cfg_valid && cfg_ready) begin
                        if (idx == IDX_LAST) begin
                            state     <= ST_CHECK;
                            idx       <= '0;
                            cfg_ready <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    state    <= ST_POST;
                    cnt      <= CNT_INIT;
                    frame_ok <= !any_bad;
                    err      <= any_bad;
                end
                ST_POST: begin
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        prog     <= 1'b0;
                        busy     <= 1'b0;
                        done     <= frame_ok;
                        frame_ok <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_mux_cfg_loader.sv
// tb/tb_clk_mux_cfg_loader.sv - randomized model-checked bench for clk_mux_cfg_loader
module tb_clk_mux_cfg_loader;

    localparam int NUM_MUX    = 8;
    localparam int SETTLE_CYC = 4;
    localparam int W          = NUM_MUX * 6;

    logic                clk = 1'b0;
    logic                rstb = 1'b0;
    logic                cfg_start = 1'b0;
    logic                cfg_abort = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [6:0]          cfg_data = '0;
    logic                cfg_ready, busy, done, err, prog;
    logic [W-1:0]        cbit, cbitb;
    logic [NUM_MUX-1:0]  cenb;

    always #5 clk = ~clk;

    clk_mux_cfg_loader #(.NUM_MUX(NUM_MUX), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rstb(rstb), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err), .prog(prog),
        .cbit(cbit), .cbitb(cbitb), .cenb(cenb)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int prog_cnt = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phases with a settle countdown and a queue of accepted words.
    localparam int P_IDLE = 0, P_PRE = 1, P_LOAD = 2, P_CHECK = 3, P_POST = 4;
    int           m_phase = P_IDLE;
    int           m_left = 0;
    logic [6:0]   m_q[$];
    bit           m_ok = 0, m_done = 0, m_err = 0;
    logic [W-1:0] m_cbit = '0;
    logic [NUM_MUX-1:0] m_cenb = '1;

    always @(posedge clk) begin : model_upd
        bit bad;
        m_done = 0;
        m_err  = 0;
        if (!rstb) begin
            m_phase = P_IDLE; m_left = 0; m_q.delete(); m_ok = 0;
            m_cbit = '0; m_cenb = '1;
        end else begin
            case (m_phase)
                P_IDLE: if (cfg_start) begin m_phase = P_PRE; m_left = SETTLE_CYC; end
                P_PRE: begin
                    if (cfg_abort) begin m_phase = P_POST; m_left = SETTLE_CYC; m_q.delete(); m_ok = 0; end
                    else begin m_left--; if (m_left == 0) m_phase = P_LOAD; end
                end
                P_LOAD: begin
                    if (cfg_abort) begin m_phase = P_POST; m_left = SETTLE_CYC; m_q.delete(); m_ok = 0; end
                    else if (cfg_valid) begin
                        m_q.push_back(cfg_data);
                        if (m_q.size() == NUM_MUX) m_phase = P_CHECK;
                    end
                end
                P_CHECK: begin
                    bad = 0;
                    foreach (m_q[j]) if (m_q[j][4] && (m_q[j][3:0] > 4'd11)) bad = 1;
                    if (!bad) begin
                        foreach (m_q[j]) begin
                            m_cbit[j*6 +: 6] = m_q[j][5:0];
                            m_cenb[j] = m_q[j][6];
                        end
                    end
                    m_err = bad; m_ok = !bad; m_q.delete();
                    m_phase = P_POST; m_left = SETTLE_CYC;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_IDLE; m_done = m_ok; m_ok = 0; end
                end
            endcase
        end
    end

    // Every cycle, compare all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cfg_ready", W'(cfg_ready), W'(m_phase == P_LOAD));
            chk("busy",      W'(busy),      W'(m_phase != P_IDLE));
            chk("prog",      W'(prog),      W'(m_phase != P_IDLE));
            chk("done",      W'(done),      W'(m_done));
            chk("err",       W'(err),       W'(m_err));
            chk("cbit",      cbit,          m_cbit);
            chk("cbitb",     cbitb,         ~m_cbit);
            chk("cenb",      W'(cenb),      W'(m_cenb));
            if (prog) prog_cnt++;
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    task automatic feed(input logic [6:0] w [NUM_MUX], input int stall_pct,
                        input int abort_at, input bit rand_start);
        int k = 0;
        int guard = 0;
        bit stop = 0;
        while (!stop) begin
            @(negedge clk);
            cfg_abort = 0;
            cfg_start = rand_start && busy && ($urandom_range(0, 3) == 0);
            cfg_valid = ($urandom_range(0, 99) >= stall_pct);
            cfg_data  = w[k];
            if (cfg_ready && k == abort_at) begin
                cfg_valid = 1; cfg_abort = 1; stop = 1;
            end else if (cfg_ready && cfg_valid) begin
                k++;
                if (k == NUM_MUX) stop = 1;
            end
            guard++;
            if (guard > 400) begin
                checks++; errors++;
                $display("FAIL feed_timeout actual=%0d words required=%0d", k, NUM_MUX);
                stop = 1;
            end
        end
        @(negedge clk);
        cfg_valid = 0; cfg_abort = 0; cfg_start = 0;
    endtask

    task automatic wait_idle(input bit restart, input bit rand_start);
        int g = 0;
        bit fin = 0;
        while (!fin) begin
            @(negedge clk);
            cfg_start = 0;
            if (!busy) begin
                if (restart) cfg_start = 1;
                fin = 1;
            end else if (rand_start && $urandom_range(0, 3) == 0) begin
                cfg_start = 1;
            end
            g++;
            if (g > 100) begin
                checks++; errors++;
                $display("FAIL idle_timeout actual=busy required=idle");
                fin = 1;
            end
        end
        @(negedge clk);
        cfg_start = 0;
    endtask

    task automatic clr_counts();
        prog_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        cfg_start = 1;
    endtask

    logic [6:0] w [NUM_MUX];

    initial begin
        rstb = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_cbit", cbit, '0);
        chk("rst_cbitb", cbitb, {W{1'b1}});
        chk("rst_cenb", W'(cenb), W'({NUM_MUX{1'b1}}));
        rstb = 1;

        // 1: good frame, mux i select=i, en=1, pol=1, cenb=0
        for (int i = 0; i < NUM_MUX; i++) w[i] = {1'b0, 1'b1, 1'b1, 4'(i)};
        clr_counts();
        start_pulse();
        feed(w, 0, -1, 0);
        wait_idle(0, 0);
        chk("t1_prog_cycles", W'(prog_cnt), W'(17));
        chk("t1_done_count", W'(done_cnt), W'(1));
        chk("t1_err_count", W'(err_cnt), W'(0));
        chk("t1_mux0", W'(cbit[5:0]), W'(6'b110000));
        chk("t1_mux3", W'(cbit[23:18]), W'(6'b110011));
        chk("t1_cenb", W'(cenb), W'(8'h00));

        // 2: word 3 enabled with select 12 rejects the frame
        for (int i = 0; i < NUM_MUX; i++) w[i] = {1'b1, 1'b0, 1'b1, 4'(7 - i)};
        w[3] = {1'b0, 1'b1, 1'b1, 4'd12};
        clr_counts();
        start_pulse();
        feed(w, 0, -1, 0);
        wait_idle(0, 0);
        chk("t2_err_count", W'(err_cnt), W'(1));
        chk("t2_done_count", W'(done_cnt), W'(0));
        chk("t2_mux3_kept", W'(cbit[23:18]), W'(6'b110011));

        // 3: disabled word with select 15 is stored verbatim
        for (int i = 0; i < NUM_MUX; i++) w[i] = {1'b0, 1'b1, 1'b1, 4'(i)};
        w[3] = {1'b0, 1'b1, 1'b0, 4'd15};
        clr_counts();
        start_pulse();
        feed(w, 0, -1, 0);
        wait_idle(0, 0);
        chk("t3_done_count", W'(done_cnt), W'(1));
        chk("t3_err_count", W'(err_cnt), W'(0));
        chk("t3_mux3", W'(cbit[23:18]), W'(6'b101111));

        // 4: abort together with the sixth valid word
        for (int i = 0; i < NUM_MUX; i++) w[i] = {1'b1, 1'b0, 1'b1, 4'(11 - i)};
        clr_counts();
        start_pulse();
        feed(w, 0, 5, 0);
        wait_idle(0, 0);
        chk("t4_prog_cycles", W'(prog_cnt), W'(14));
        chk("t4_done_count", W'(done_cnt), W'(0));
        chk("t4_err_count", W'(err_cnt), W'(0));
        chk("t4_mux3_kept", W'(cbit[23:18]), W'(6'b101111));
        chk("t4_cenb_kept", W'(cenb), W'(8'h00));

        // 5: reset in the middle of LOAD
        begin
            int acc = 0;
            int g = 0;
            start_pulse();
            while (acc < 2 && g < 50) begin
                @(negedge clk);
                cfg_start = 0;
                cfg_valid = 1;
                cfg_data  = 7'h15;
                if (cfg_ready) acc++;
                g++;
            end
            @(negedge clk);
            rstb = 0; cfg_valid = 0;
            @(negedge clk);
            chk("t5_cbit", cbit, '0);
            chk("t5_cbitb", cbitb, {W{1'b1}});
            chk("t5_cenb", W'(cenb), W'({NUM_MUX{1'b1}}));
            chk("t5_prog", W'(prog), W'(0));
            chk("t5_busy", W'(busy), W'(0));
            rstb = 1;
        end

        // 6: stalls, ignored starts while busy, restart in the done cycle
        for (int i = 0; i < NUM_MUX; i++)
            w[i] = {1'($urandom), 1'($urandom), 1'b1, 4'($urandom_range(0, 11))};
        clr_counts();
        start_pulse();
        feed(w, 40, -1, 1);
        wait_idle(1, 1);
        for (int i = 0; i < NUM_MUX; i++)
            w[i] = {1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 11))};
        feed(w, 40, -1, 0);
        wait_idle(0, 0);
        chk("t6_done_count", W'(done_cnt), W'(2));

        // Random frames: arbitrary words, stalls and occasional aborts
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < NUM_MUX; i++) w[i] = 7'($urandom);
            start_pulse();
            feed(w, 30, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_MUX - 1)) : -1, 1);
            wait_idle(0, 1);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
